// File: rtl/operand_fetch_pkg.sv
// Shared defines for the operand-fetch stage.
// Contents: datapath width (REG_BUS), all-zero word (ZERO_WORD),
// register-index width, register count, the default micro-op width,
// and a helper that decides whether a source operand really reads a register.
package operand_fetch_pkg;

  localparam int REG_BUS   = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int UOP_W_DEF = 16;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // r0 is hard-wired to zero, so it never participates in hazards or bypasses.
  function automatic logic src_active(input logic used, input reg_idx_t idx);
    return used && (idx != '0);
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-writer scoreboard: one busy bit per architectural register.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   set_i      mark set_idx_i as having a writer in flight
//   set_idx_i  index to mark
//   clr_i      a writer of clr_idx_i has reached writeback
//   clr_idx_i  index to clear
//   flush_i    clear every busy bit
//   busy_o     busy vector; bit 0 is always 0
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  reg_idx_t            set_idx_i,
  input  logic                clr_i,
  input  reg_idx_t            clr_idx_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // The set is applied after the clear: a writer issuing in the same cycle
  // its predecessor retires must keep the register marked busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_i) begin
      busy_d[set_idx_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-read stage between decode and execute.
// Drives the register-file read ports, applies EX and writeback bypasses,
// stalls on RAW/WAW hazards via a pending-writer scoreboard, and holds the
// resolved operands in a single valid/ready output register.
// Ports:
//   clk, rst (async, active-low)
//   in_*        decoded instruction from the decoder (valid/ready)
//   rf_r_*      register-file read ports (combinational data return)
//   ex_fwd_*    final result available in EX this cycle
//   wb_*        writeback port (also writes the register file)
//   flush       kill the held instruction and clear the scoreboard
//   out_*       resolved instruction towards EX (valid/ready)
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int REG_W = REG_BUS,
  parameter int UOP_W = UOP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic             in_rs1_use,
  input  logic             in_rs2_use,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  input  logic [UOP_W-1:0] in_uop,
  output logic [4:0]       rf_r_addr1,
  output logic [4:0]       rf_r_addr2,
  output logic             rf_r_ena1,
  output logic             rf_r_ena2,
  input  logic [REG_W-1:0] rf_r_data1,
  input  logic [REG_W-1:0] rf_r_data2,
  input  logic             ex_fwd_valid,
  input  logic [4:0]       ex_fwd_addr,
  input  logic [REG_W-1:0] ex_fwd_data,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [REG_W-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_op1,
  output logic [REG_W-1:0] out_op2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic [UOP_W-1:0] out_uop
);

  logic [NUM_REGS-1:0] pend;

  logic             src1_act;
  logic             src2_act;
  logic             ex_hit1;
  logic             ex_hit2;
  logic             wb_hit1;
  logic             wb_hit2;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             hazard;
  logic             adv;
  logic             acc;
  logic             sb_set;
  logic             sb_clr;
  logic [REG_W-1:0] op1_d;
  logic [REG_W-1:0] op2_d;

  logic             out_valid_q;
  logic             out_valid_d;
  logic [REG_W-1:0] op1_q;
  logic [REG_W-1:0] op2_q;
  logic [4:0]       rd_q;
  logic             rd_we_q;
  logic [UOP_W-1:0] uop_q;

  // Bypass priority: EX result is younger than the writeback value, which in
  // turn is younger than the register file (written only at the clock edge).
  function automatic logic [REG_W-1:0] resolve(
    input logic             active,
    input logic             ex_hit,
    input logic             wb_hit,
    input logic [REG_W-1:0] ex_val,
    input logic [REG_W-1:0] wb_val,
    input logic [REG_W-1:0] rf_val
  );
    if (!active) return REG_W'(ZERO_WORD);
    if (ex_hit)  return ex_val;
    if (wb_hit)  return wb_val;
    return rf_val;
  endfunction

  assign rf_r_addr1 = in_rs1;
  assign rf_r_addr2 = in_rs2;
  assign rf_r_ena1  = in_valid & in_rs1_use;
  assign rf_r_ena2  = in_valid & in_rs2_use;

  assign src1_act = src_active(in_rs1_use, in_rs1);
  assign src2_act = src_active(in_rs2_use, in_rs2);
  assign ex_hit1  = ex_fwd_valid && (ex_fwd_addr == in_rs1);
  assign ex_hit2  = ex_fwd_valid && (ex_fwd_addr == in_rs2);
  assign wb_hit1  = wb_we && (wb_addr == in_rs1);
  assign wb_hit2  = wb_we && (wb_addr == in_rs2);

  assign op1_d = resolve(src1_act, ex_hit1, wb_hit1, ex_fwd_data, wb_data, rf_r_data1);
  assign op2_d = resolve(src2_act, ex_hit2, wb_hit2, ex_fwd_data, wb_data, rf_r_data2);

  // A pending source is fine as long as its value is visible on a bypass now.
  assign raw1 = src1_act && pend[in_rs1] && !ex_hit1 && !wb_hit1;
  assign raw2 = src2_act && pend[in_rs2] && !ex_hit2 && !wb_hit2;
  // The older writer retiring this cycle frees the slot for the new one.
  assign waw  = in_rd_we && (in_rd != '0) && pend[in_rd] &&
                !(wb_we && (wb_addr == in_rd));
  assign hazard = raw1 | raw2 | waw;

  assign adv      = !out_valid_q | out_ready;
  // rst gates in_ready so nothing is accepted while reset is held.
  assign in_ready = rst & adv & !hazard & !flush;
  assign acc      = in_valid & in_ready;

  assign sb_set = acc && in_rd_we && (in_rd != '0);
  assign sb_clr = wb_we && (wb_addr != '0);

  operand_fetch_scoreboard u_sb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .set_i     (sb_set),
    .set_idx_i (in_rd),
    .clr_i     (sb_clr),
    .clr_idx_i (wb_addr),
    .flush_i   (flush),
    .busy_o    (pend)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (acc) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      uop_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (acc) begin
        op1_q   <= op1_d;
        op2_q   <= op2_d;
        rd_q    <= in_rd;
        rd_we_q <= in_rd_we;
        uop_q   <= in_uop;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;
  assign out_uop   = uop_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_rs1_use;
  logic        in_rs2_use;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [15:0] in_uop;
  logic [4:0]  rf_r_addr1;
  logic [4:0]  rf_r_addr2;
  logic        rf_r_ena1;
  logic        rf_r_ena2;
  logic [31:0] rf_r_data1;
  logic [31:0] rf_r_data2;
  logic        ex_fwd_valid;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [15:0] out_uop;

  operand_fetch #(.REG_W(32), .UOP_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_uop(in_uop),
    .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2),
    .rf_r_ena1(rf_r_ena1), .rf_r_ena2(rf_r_ena2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_uop(out_uop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] uop;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic [15:0] uop);
    in_valid = v; in_rs1 = rs1; in_rs1_use = u1; in_rs2 = rs2; in_rs2_use = u2;
    in_rd = rd; in_rd_we = we; in_uop = uop;
  endtask

  // Inputs are already applied at the falling edge; check in_ready, record the
  // expected output if the instruction should be accepted, then advance.
  task automatic step(input string nm, input logic exp_rdy,
                      input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    #1;
    chk(nm, in_ready, exp_rdy);
    if (exp_rdy && in_valid) begin
      e.op1 = e1; e.op2 = e2; e.rd = in_rd; e.we = in_rd_we; e.uop = in_uop;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Monitor: every transfer to EX pops and compares one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_xfer: unexpected output uop=%0h op1=%0h", out_uop, out_op1);
        end else begin
          e = exp_q.pop_front();
          chk("out_op1", out_op1, e.op1);
          chk("out_op2", out_op2, e.op2);
          chk("out_rd_uop", {out_rd, out_rd_we, out_uop}, {e.rd, e.we, e.uop});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    rf_r_data1 = '0; rf_r_data2 = '0;
    ex_fwd_valid = 0; ex_fwd_addr = '0; ex_fwd_data = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;
    flush = 0; out_ready = 1;

    // Reset state
    @(negedge clk);
    set_in(1, 6, 1, 0, 0, 0, 0, 16'h0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ops", {out_op1, out_op2}, 64'h0);
    chk("rst_out_rd", {out_rd, out_rd_we, out_uop}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_ena1", rf_r_ena1, 1);
    chk("rst_rf_ena2", rf_r_ena2, 0);
    chk("rf_addr1", rf_r_addr1, 5'd6);
    @(negedge clk);
    rst = 1'b1;

    // Independent back-to-back stream
    set_in(1, 1, 1, 2, 1, 0, 0, 16'h0101);
    rf_r_data1 = 32'h11; rf_r_data2 = 32'h22;
    step("indep1_rdy", 1, 32'h11, 32'h22);
    set_in(1, 3, 1, 4, 1, 0, 0, 16'h0102);
    rf_r_data1 = 32'h33; rf_r_data2 = 32'h44;
    step("indep2_rdy", 1, 32'h33, 32'h44);

    // RAW through WB
    set_in(1, 0, 0, 0, 0, 5, 1, 16'h0201);
    step("raw_wr_rdy", 1, 0, 0);
    set_in(1, 5, 1, 0, 0, 0, 0, 16'h0202);
    rf_r_data1 = 32'h99;
    step("raw_stall1", 0, 0, 0);
    step("raw_stall2", 0, 0, 0);
    wb_we = 1; wb_addr = 5; wb_data = 32'hABCD;
    step("raw_wb_rdy", 1, 32'hABCD, 0);
    wb_we = 0;

    // EX bypass
    set_in(1, 0, 0, 0, 0, 7, 1, 16'h0301);
    step("ex_wr_rdy", 1, 0, 0);
    set_in(1, 0, 0, 7, 1, 0, 0, 16'h0302);
    rf_r_data2 = 32'h0;
    ex_fwd_valid = 1; ex_fwd_addr = 7; ex_fwd_data = 32'h55;
    step("ex_byp_rdy", 1, 0, 32'h55);
    ex_fwd_valid = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    wb_we = 1; wb_addr = 7; wb_data = 32'h55;
    step("ex_wbclr_rdy", 1, 0, 0);
    wb_we = 0;

    // WAW
    set_in(1, 0, 0, 0, 0, 3, 1, 16'h0401);
    step("waw_wr1_rdy", 1, 0, 0);
    set_in(1, 0, 0, 0, 0, 3, 1, 16'h0402);
    step("waw_stall", 0, 0, 0);
    wb_we = 1; wb_addr = 3; wb_data = 32'h333;
    step("waw_wb_rdy", 1, 0, 0);
    wb_we = 0;
    set_in(1, 3, 1, 0, 0, 0, 0, 16'h0403);
    rf_r_data1 = 32'h5;
    step("waw_pend_kept", 0, 0, 0);
    wb_we = 1; wb_addr = 3; wb_data = 32'h3333;
    step("waw_rd_rdy", 1, 32'h3333, 0);
    wb_we = 0;

    // Backpressure and flush
    set_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step("bp_idle", 1, 0, 0);
    out_ready = 0;
    set_in(1, 0, 0, 0, 0, 9, 1, 16'hBEEF);
    step("bp_load_rdy", 1, 0, 0);
    exp_q.pop_back(); // this instruction will be flushed, never reaching EX
    set_in(1, 1, 1, 0, 0, 0, 0, 16'h0501);
    rf_r_data1 = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      step("bp_stall_rdy", 0, 0, 0);
      chk("bp_hold", {out_valid, out_rd, out_rd_we, out_uop}, {1'b1, 5'd9, 1'b1, 16'hBEEF});
    end
    flush = 1;
    step("flush_rdy", 0, 0, 0);
    flush = 0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1;
    set_in(1, 9, 1, 0, 0, 0, 0, 16'h0502);
    rf_r_data1 = 32'h77;
    step("flush_pend_clr", 1, 32'h77, 0);

    // r0 reads as zero; rd=0 never marks busy
    set_in(1, 0, 1, 2, 1, 0, 1, 16'h0601);
    rf_r_data1 = 32'hFFFF; rf_r_data2 = 32'h22;
    step("r0_rdy", 1, 0, 32'h22);

    // Async reset mid-stall
    set_in(1, 0, 0, 0, 0, 12, 1, 16'h0701);
    step("ar_wr_rdy", 1, 0, 0);
    out_ready = 0;
    set_in(1, 12, 1, 0, 0, 0, 0, 16'h0702);
    rf_r_data1 = 32'h6161;
    #1;
    chk("ar_stall", in_ready, 0);
    chk("ar_held", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    exp_q.pop_back(); // held writer is destroyed by reset
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", {out_op1, out_rd, out_rd_we, out_uop}, 0);
    chk("ar_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1;
    step("ar_pend_clr", 1, 32'h6161, 0);

    // Drain
    set_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
